even_parity_checker: RTL and testbench
======================================

EVEN_PARITY_CHECKER -- requirements
Module: even_parity_checker

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, width of the saturating error counter.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port serial_in  input  1  serial line bit; idle level 1.
REQ-005 The module SHALL have port bit_valid  input  1  strobe; serial_in is sampled only on cycles where bit_valid=1.
REQ-006 The module SHALL have port clear_err  input  1  synchronous clear of err_count.
REQ-007 The module SHALL have port data_out  output  3  last received data bits {D2,D1,D0}.
REQ-008 The module SHALL have port par_err  output  1  even-parity failure of the last frame.
REQ-009 The module SHALL have port frame_err  output  1  stop bit of the last frame was 0.
REQ-010 The module SHALL have port out_valid  output  1  one-cycle pulse: data_out/par_err/frame_err updated.
REQ-011 The module SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-012 The module SHALL have port err_count  output  CNT_W  count of frames with par_err or frame_err.

Function
REQ-013 The frame SHALL be serial, in order: start(0), D2, D1, D0, P, stop(1), one bit per bit_valid strobe; this is the inverse of the 3-bit-data/1-parity even-parity word {A[2:0],P}.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-015 In IDLE, a strobe with serial_in=1 SHALL be ignored; a strobe with serial_in=0 SHALL move to DATA with bit index 2.
REQ-016 In DATA, each strobe SHALL store serial_in into the current index (2, then 1, then 0); after index 0, the FSM SHALL move to PARITY.
REQ-017 In PARITY, a strobe SHALL capture P and move to STOP.
REQ-018 In STOP, a strobe SHALL capture the stop bit and return to IDLE.
REQ-019 While bit_valid=0, the FSM state, bit index and captured bits SHALL hold.
REQ-020 The output registers SHALL update on the clock edge following the stop-bit strobe, with out_valid=1 for exactly that one cycle; latency is 1 cycle from the stop-bit sample.
REQ-021 On that update, data_out SHALL equal {D2,D1,D0} and par_err SHALL equal D2^D1^D0^P, i.e. 1 when the count of ones is odd.
REQ-022 On that update, frame_err SHALL equal the inverse of the stop bit.
REQ-023 A frame with frame_err=1 SHALL still update data_out and par_err.
REQ-024 data_out, par_err and frame_err SHALL hold their values between out_valid pulses.
REQ-025 err_count SHALL increment by exactly 1 per frame with (par_err|frame_err)=1, coincident with out_valid.
REQ-026 err_count SHALL saturate at 2^CNT_W-1.
REQ-027 clear_err=1 SHALL set err_count to 0 on the next edge; clear_err SHALL win over a simultaneous increment.
REQ-028 A start bit SHALL be accepted in IDLE on the same cycle out_valid is high, so back-to-back frames are supported.
REQ-029 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-030 While rst_n=0, the module SHALL immediately force state IDLE, bit index 2, captured bits 0, data_out=0, par_err=0, frame_err=0, out_valid=0, busy=0 and err_count=0.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame without an out_valid pulse; after release, the next start bit SHALL begin a new frame.

Verification
REQ-032 The bench SHALL send strobed bits 0,1,0,1,0,1 and check: one cycle after the last strobe, out_valid=1, data_out=3'b101, par_err=0, frame_err=0, err_count=0.
REQ-033 The bench SHALL send bits 0,1,1,0,1,1 (data 110, P=1 wrong) and check: data_out=3'b110, par_err=1, err_count increments by 1.
REQ-034 The bench SHALL send bits 0,1,1,1,1,0 (stop=0) and check: data_out=3'b111, par_err=0, frame_err=1, err_count +1.
REQ-035 The bench SHALL insert bit_valid=0 gaps of 0-5 cycles between bits, plus idle 1-strobes before the start bit, and check results are identical to the ungapped frames.
REQ-036 The bench SHALL drop rst_n low after 3 bits of a frame, then send frame 0,0,0,1,1,1, and check: no out_valid pulse during reset, then data_out=3'b001, par_err=0.
REQ-037 The bench SHALL send 300 bad frames with CNT_W=8 and check err_count=255; clear_err asserted with a bad-frame out_valid SHALL leave err_count=0.

Source files
------------

// File: rtl/even_parity_checker.sv
// Serial receiver for start/D2/D1/D0/P/stop frames: checks even parity and the stop bit,
// and keeps a saturating count of bad frames.
module even_parity_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             clear_err,
  output logic [2:0]       data_out,
  output logic             par_err,
  output logic             frame_err,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [2:0]       r_bits;
  logic [2:0]       w_bits_nxt;
  logic             r_par;
  logic             w_par_nxt;
  logic             w_done;
  logic             w_par_err;
  logic             w_frame_err;

  logic [2:0]       r_data_out;
  logic             r_par_err;
  logic             r_frame_err;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_err_count;

  // State register and frame capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd2;
      r_bits  <= 3'd0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_bits  <= w_bits_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Next-state logic; everything holds on cycles without a strobe
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bits_nxt  = r_bits;
    w_par_nxt   = r_par;
    w_done      = 1'b0;
    if (bit_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (!serial_in) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = 2'd2;
          end
        end
        S_DATA: begin
          case (r_idx)
            2'd2:    w_bits_nxt[2] = serial_in;
            2'd1:    w_bits_nxt[1] = serial_in;
            default: w_bits_nxt[0] = serial_in;
          endcase
          if (r_idx == 2'd0) begin
            w_state_nxt = S_PARITY;
            w_idx_nxt   = 2'd2;
          end else begin
            w_idx_nxt = r_idx - 2'd1;
          end
        end
        S_PARITY: begin
          w_par_nxt   = serial_in;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The stop bit is consumed directly from the line on its strobe
  assign w_par_err   = ^{r_bits, r_par};
  assign w_frame_err = ~serial_in;

  // Result registers, busy flag and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= 3'd0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_out_valid <= w_done;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_done) begin
        r_data_out  <= r_bits;
        r_par_err   <= w_par_err;
        r_frame_err <= w_frame_err;
      end
      if (clear_err) begin
        r_err_count <= '0;
      end else if (w_done && (w_par_err || w_frame_err) && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign data_out  = r_data_out;
  assign par_err   = r_par_err;
  assign frame_err = r_frame_err;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_even_parity_checker.sv
// Randomized self-checking bench for even_parity_checker against a frame-level model.
module tb_even_parity_checker;

  localparam int unsigned CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             serial_in = 1'b1;
  logic             bit_valid = 1'b0;
  logic             clear_err = 1'b0;
  logic [2:0]       data_out;
  logic             par_err;
  logic             frame_err;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] err_count;

  int n_chk = 0;
  int n_pass = 0;
  int n_ov = 0;
  int frames_done = 0;
  int exp_cnt = 0;
  logic [2:0] exp_data = 3'd0;

  even_parity_checker #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .clear_err (clear_err),
    .data_out  (data_out),
    .par_err   (par_err),
    .frame_err (frame_err),
    .out_valid (out_valid),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Count every cycle that out_valid is high
  always @(negedge clk) if (out_valid) n_ov++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One strobed bit after `gap` idle cycles; returns at posedge+1
  task automatic strobe(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      bit_valid = 1'b0;
      @(posedge clk); #1;
    end
    bit_valid = 1'b1;
    serial_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  // f = {start, D2, D1, D0, P, stop}, sent MSB first
  task automatic send_frame(input logic [5:0] f, input int max_gap, input int idle, input logic clr);
    logic [2:0] d;
    logic       p;
    logic       stop;
    logic       e_par;
    logic       e_fe;
    d    = f[4:2];
    p    = f[1];
    stop = f[0];
    for (int i = 0; i < idle; i++) begin
      strobe(1'b1, $urandom_range(0, max_gap));
      chk("idle_busy", 32'(busy), 32'd0);
    end
    strobe(f[5], $urandom_range(0, max_gap));
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 4; i >= 1; i--) strobe(f[i], $urandom_range(0, max_gap));
    chk("ov_count", 32'(n_ov), 32'(frames_done));
    chk("hold_data", 32'(data_out), 32'(exp_data));
    chk("ov_low", 32'(out_valid), 32'd0);
    clear_err = clr;
    strobe(stop, $urandom_range(0, max_gap));
    clear_err = 1'b0;
    // Model: parity error when the number of ones in {D,P} is odd
    e_par = ($countones({d, p}) % 2) == 1;
    e_fe  = (stop == 1'b0);
    if (clr) exp_cnt = 0;
    else if ((e_par || e_fe) && exp_cnt < CNT_SAT) exp_cnt = exp_cnt + 1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("data_out", 32'(data_out), 32'(d));
    chk("par_err", 32'(par_err), 32'(e_par));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("err_count", 32'(err_count), 32'(exp_cnt));
    chk("busy_end", 32'(busy), 32'd0);
    frames_done++;
    exp_data = d;
  endtask

  initial begin
    logic [3:0] dp;
    logic       stop;
    #2;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_par", 32'(par_err), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frames without gaps, then the same frames gapped with idle strobes
    send_frame(6'b010101, 0, 0, 1'b0);
    send_frame(6'b011011, 0, 0, 1'b0);
    send_frame(6'b011110, 0, 0, 1'b0);
    send_frame(6'b010101, 5, 3, 1'b0);
    send_frame(6'b011011, 5, 2, 1'b0);
    send_frame(6'b011110, 5, 1, 1'b0);

    // Random frames; max_gap 0 with no idle gives back-to-back frames
    for (int k = 0; k < 60; k++) begin
      dp   = 4'($urandom_range(0, 15));
      stop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) send_frame({1'b0, dp, stop}, 0, 0, 1'b0);
      else send_frame({1'b0, dp, stop}, 5, $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a frame
    strobe(1'b0, 0);
    strobe(1'b1, 1);
    strobe(1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_cnt", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt  = 0;
    exp_data = 3'd0;
    @(posedge clk); #1;
    send_frame(6'b000111, 0, 0, 1'b0);

    // Saturation of the error counter, then clear winning over an increment
    for (int k = 0; k < 300; k++) send_frame(6'b011011, 0, 0, 1'b0);
    chk("sat_cnt", 32'(err_count), 32'(CNT_SAT));
    send_frame(6'b011011, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_hold", 32'(err_count), 32'd0);
    chk("final_ov_count", 32'(n_ov), 32'(frames_done));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
